// File: rtl/weight_loader_pkg.sv
// Shared constants and types for the framed weight-load receiver.
// Holds the sync byte, the error encodings and the parser state set.
package weight_loader_pkg;

  localparam int unsigned DEFAULT_DATA_WIDTH = 16;
  localparam logic [7:0]  SYNC_BYTE          = 8'hA5;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'd0,
    ERR_RANGE   = 2'd1,
    ERR_CSUM    = 2'd2,
    ERR_TIMEOUT = 2'd3
  } err_code_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_COUNT,
    S_DATA,
    S_CSUM
  } state_t;

endpackage

// File: rtl/weight_loader_timeout.sv
// Inter-byte idle watchdog for frames in progress.
// Counts idle clocks while enabled; a kick clears it.
module weight_loader_timeout #(
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  input  logic kick,
  output logic expired
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (!enable || kick) begin
      cnt <= '0;
    end else if (cnt != CW'(TIMEOUT_CYCLES)) begin
      cnt <= cnt + CW'(1);
    end
  end

  // Fires on the idle clock whose edge brings the count to TIMEOUT_CYCLES.
  assign expired = enable && !kick && (cnt == CW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/weight_loader.sv
// Parses the SYNC/ADDR/COUNT/data/CSUM byte stream from the UART receiver
// and writes little-endian assembled words into the weight memory.
module weight_loader
  import weight_loader_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = DEFAULT_DATA_WIDTH,
  parameter int unsigned MEM_DEPTH      = 64,
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         rx_valid,
  input  logic [7:0]                   rx_data,
  output logic                         write_en,
  output logic [7:0]                   write_addr,
  output logic signed [DATA_WIDTH-1:0] write_data,
  output logic                         busy,
  output logic                         load_done,
  output logic                         load_error,
  output logic [1:0]                   err_code
);

  localparam int unsigned BYTES = DATA_WIDTH / 8;

  state_t                state;
  logic [7:0]            start_addr;
  logic [7:0]            word_total;
  logic [7:0]            word_idx;
  logic [7:0]            byte_idx;
  logic [7:0]            csum;
  logic [DATA_WIDTH-1:0] asm_word;
  logic [DATA_WIDTH-1:0] next_word;
  logic [8:0]            range_end;
  logic                  expired;

  weight_loader_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (clk),
    .rst_n  (rst_n),
    .enable (state != S_IDLE),
    .kick   (rx_valid),
    .expired(expired)
  );

  // LS byte arrives first, so each new byte enters at the top and shifts down.
  always_comb begin
    next_word = (asm_word >> 8) | (DATA_WIDTH'(rx_data) << (DATA_WIDTH - 8));
    range_end = {1'b0, start_addr} + {1'b0, rx_data};
  end

  assign busy = (state != S_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      start_addr <= '0;
      word_total <= '0;
      word_idx   <= '0;
      byte_idx   <= '0;
      csum       <= '0;
      asm_word   <= '0;
      write_en   <= 1'b0;
      write_addr <= '0;
      write_data <= '0;
      load_done  <= 1'b0;
      load_error <= 1'b0;
      err_code   <= ERR_NONE;
    end else begin
      write_en   <= 1'b0;
      load_done  <= 1'b0;
      load_error <= 1'b0;
      if (expired) begin
        state      <= S_IDLE;
        load_error <= 1'b1;
        err_code   <= ERR_TIMEOUT;
      end else if (rx_valid) begin
        case (state)
          S_IDLE: begin
            if (rx_data == SYNC_BYTE) begin
              state    <= S_ADDR;
              csum     <= '0;
              byte_idx <= '0;
              word_idx <= '0;
              err_code <= ERR_NONE;
            end
          end
          S_ADDR: begin
            start_addr <= rx_data;
            csum       <= csum ^ rx_data;
            state      <= S_COUNT;
          end
          S_COUNT: begin
            csum <= csum ^ rx_data;
            if (rx_data == 8'd0 || range_end > 9'(MEM_DEPTH)) begin
              state      <= S_IDLE;
              load_error <= 1'b1;
              err_code   <= ERR_RANGE;
            end else begin
              word_total <= rx_data;
              state      <= S_DATA;
            end
          end
          S_DATA: begin
            csum     <= csum ^ rx_data;
            asm_word <= next_word;
            if (byte_idx == 8'(BYTES - 1)) begin
              byte_idx   <= '0;
              write_en   <= 1'b1;
              write_addr <= start_addr + word_idx;
              write_data <= next_word;
              word_idx   <= word_idx + 8'd1;
              if (word_idx == word_total - 8'd1) state <= S_CSUM;
            end else begin
              byte_idx <= byte_idx + 8'd1;
            end
          end
          S_CSUM: begin
            state <= S_IDLE;
            if (rx_data == csum) begin
              load_done <= 1'b1;
              err_code  <= ERR_NONE;
            end else begin
              load_error <= 1'b1;
              err_code   <= ERR_CSUM;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_weight_loader.sv
// Directed-vector bench for weight_loader with hand-computed expectations.
module tb_weight_loader;

  localparam int unsigned TMO = 40;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        write_en;
  logic [7:0]  write_addr;
  logic [15:0] write_data;
  logic        busy;
  logic        load_done;
  logic        load_error;
  logic [1:0]  err_code;

  int n_vec  = 0;
  int n_miss = 0;
  int wr_total = 0;
  int we_run = 0;
  int we_max_run = 0;
  int both_seen = 0;

  weight_loader #(
    .DATA_WIDTH    (16),
    .MEM_DEPTH     (64),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx_valid  (rx_valid),
    .rx_data   (rx_data),
    .write_en  (write_en),
    .write_addr(write_addr),
    .write_data(write_data),
    .busy      (busy),
    .load_done (load_done),
    .load_error(load_error),
    .err_code  (err_code)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (write_en) begin
      wr_total++;
      we_run++;
      if (we_run > we_max_run) we_max_run = we_run;
    end else begin
      we_run = 0;
    end
    if (load_done && load_error) both_seen = 1;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Drives one byte for one cycle; returns #1 after the sampling edge.
  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = b;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "bench watchdog expired");
  end

  initial begin
    int cyc;
    rst_n    = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    idle(3);
    check_val("reset_outputs",
      {write_en, write_addr, write_data, busy, load_done, load_error, err_code}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(2);

    // Nominal two-word frame
    send_byte(8'hA5); check_val("nom_busy", busy, 1);
    send_byte(8'h00);
    send_byte(8'h02);
    send_byte(8'h34); check_val("nom_no_we_mid", write_en, 0);
    send_byte(8'h12);
    check_val("nom_we0", write_en, 1);
    check_val("nom_addr0", write_addr, 32'h00);
    check_val("nom_data0", write_data, 32'h1234);
    send_byte(8'hCD);
    send_byte(8'hAB);
    check_val("nom_we1", write_en, 1);
    check_val("nom_addr1", write_addr, 32'h01);
    check_val("nom_data1", write_data, 32'hABCD);
    send_byte(8'h42);
    check_val("nom_done", load_done, 1);
    check_val("nom_err", {load_error, err_code}, 0);
    check_val("nom_idle", busy, 0);
    idle(2);
    check_val("nom_wr_total", wr_total, 2);

    // Range error: 0x3F + 2 = 0x41 > 64
    send_byte(8'hA5); send_byte(8'h3F); send_byte(8'h02);
    check_val("rng_error", load_error, 1);
    check_val("rng_code", err_code, 1);
    check_val("rng_idle", busy, 0);
    idle(1);
    check_val("rng_code_held", err_code, 1);
    send_byte(8'hA5);
    check_val("sync_clears_code", err_code, 0);
    send_byte(8'h00); send_byte(8'h00);
    check_val("cnt0_error", load_error, 1);
    check_val("cnt0_code", err_code, 1);
    check_val("cnt0_idle", busy, 0);
    idle(2);
    check_val("rng_no_write", wr_total, 2);

    // Bad checksum: expected 00^01^FF^7F = 0x81, sent 0x00
    send_byte(8'hA5); send_byte(8'h00); send_byte(8'h01); send_byte(8'hFF);
    send_byte(8'h7F);
    check_val("csum_we", write_en, 1);
    check_val("csum_data", write_data, 32'h7FFF);
    send_byte(8'h00);
    check_val("csum_error", load_error, 1);
    check_val("csum_done_low", load_done, 0);
    check_val("csum_code", err_code, 2);
    idle(2);
    check_val("csum_wr_total", wr_total, 3);

    // Timeout after a partial word
    send_byte(8'hA5); send_byte(8'h05); send_byte(8'h01); send_byte(8'h11);
    cyc = 0;
    while (!load_error && cyc < int'(TMO) + 20) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check_val("tmo_error", load_error, 1);
    check_val("tmo_latency", cyc, TMO);
    check_val("tmo_code", err_code, 3);
    check_val("tmo_idle", busy, 0);
    idle(2);
    check_val("tmo_no_write", wr_total, 3);
    // Recovery frame: 05^01^22^33 = 0x15
    send_byte(8'hA5); send_byte(8'h05); send_byte(8'h01); send_byte(8'h22);
    send_byte(8'h33);
    check_val("rec_addr", write_addr, 32'h05);
    check_val("rec_data", write_data, 32'h3322);
    send_byte(8'h15);
    check_val("rec_done", load_done, 1);
    check_val("rec_code", err_code, 0);

    // Noise then back-to-back frame with A5 as data
    send_byte(8'h00); send_byte(8'h55);
    check_val("noise_idle", busy, 0);
    send_byte(8'hA5); send_byte(8'h10); send_byte(8'h01); send_byte(8'hAA);
    send_byte(8'hA5);
    check_val("b2b_we", write_en, 1);
    check_val("b2b_addr", write_addr, 32'h10);
    check_val("b2b_data", write_data, 32'hA5AA);
    send_byte(8'h1E);
    check_val("b2b_done", load_done, 1);
    idle(2);
    check_val("b2b_wr_total", wr_total, 5);

    // Reset mid-frame after the first data byte
    send_byte(8'hA5); send_byte(8'h08); send_byte(8'h01); send_byte(8'h44);
    check_val("rst_pre_busy", busy, 1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_val("rst_outputs",
      {write_en, write_addr, write_data, busy, load_done, load_error, err_code}, 32'h0);
    idle(3);
    @(negedge clk);
    rst_n = 1'b1;
    idle(1);
    check_val("rst_no_write", wr_total, 5);
    // 08^01^44^55 = 0x18
    send_byte(8'hA5); send_byte(8'h08); send_byte(8'h01); send_byte(8'h44);
    send_byte(8'h55);
    check_val("post_rst_addr", write_addr, 32'h08);
    check_val("post_rst_data", write_data, 32'h5544);
    send_byte(8'h18);
    check_val("post_rst_done", load_done, 1);
    idle(3);
    check_val("final_wr_total", wr_total, 6);
    check_val("we_single_cycle", we_max_run, 1);
    check_val("done_err_exclusive", both_seen, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/weight_loader.md
Name: weight_loader

Overview:
UART-side writer for the weight memory. Consumes the received byte stream from the UART receiver and parses a framed weight-load protocol. Assembles `DATA_WIDTH`-bit signed words and drives the weight memory write port (write_en/write_addr/write_data). Reports frame completion and errors to the control logic.

Parameters:
- DATA_WIDTH, `DATA_WIDTH from defines.vh (16): word width; must be a multiple of 8.
- MEM_DEPTH, 64: number of weight memory entries.
- TIMEOUT_CYCLES, 100000: maximum idle clocks between bytes inside a frame.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- rx_valid  in  1  one-cycle strobe; rx_data is valid
- rx_data  in  8  received byte
- write_en  out  1  weight memory write strobe
- write_addr  out  8  weight memory write address
- write_data  out  DATA_WIDTH  signed weight word
- busy  out  1  high while a frame is in progress (any state other than IDLE)
- load_done  out  1  one-cycle pulse: frame accepted
- load_error  out  1  one-cycle pulse: frame rejected
- err_code  out  2  0 none, 1 bad range/count, 2 checksum, 3 timeout; held until the next frame starts

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous and active-low (rst_n).
- Reset values: all outputs 0; FSM in IDLE; checksum, byte counter, word counter and timeout counter cleared.
- Frame format: SYNC(0xA5), START_ADDR, COUNT, then COUNT words of BYTES = DATA_WIDTH/8 bytes each (little-endian, LS byte first), then CSUM.
- Checksum rule: CSUM is the XOR of every byte after SYNC, up to and including the last data byte.
- IDLE:
  - rx_valid with 0xA5 goes to ADDR and clears the checksum.
  - Any other byte is ignored silently.
- ADDR: latch START_ADDR, go to COUNT.
- COUNT: error code 1 if COUNT == 0 or START_ADDR + COUNT > MEM_DEPTH, computed in 9 bits. On error: load_error pulse and return to IDLE with no writes. Otherwise go to DATA.
- DATA:
  - Shift bytes into the assembly register.
  - When byte BYTES of a word arrives, write_en is high for exactly one cycle on the next clock, with write_addr = START_ADDR + word_index and write_data = the assembled word.
  - After word COUNT, go to CSUM.
- CSUM:
  - On match: load_done pulse on the next cycle, err_code = 0, go to IDLE.
  - On mismatch: load_error pulse, err_code = 2, go to IDLE.
  - Words already written stay written; there is no rollback. The host must reload.
- Timeout:
  - In any non-IDLE state, the counter increments each cycle without rx_valid and resets on rx_valid.
  - Reaching TIMEOUT_CYCLES gives load_error, err_code = 3, and a return to IDLE; a partial word is discarded.
- Inside a frame, 0xA5 is treated as data with no resync.
- Only one byte is handled per rx_valid; back-to-back rx_valid on consecutive cycles must be accepted.
- Reset mid-frame: immediate return to IDLE. A write_en pending at that moment is suppressed.
- err_code clears to 0 on SYNC acceptance.
- load_done and load_error are never asserted in the same cycle.

Decomposition:
- Shared defines (defines.vh): the SYNC byte constant 0xA5, the err_code encodings and the FSM state encodings. `DATA_WIDTH is already there.
- Sub-module: the timeout counter, as weight_loader_timeout (enable, kick, expired).
- The FSM, assembler and checksum stay in the top module.

Test Plan (DATA_WIDTH=16):
- Nominal frame: bytes A5 00 02 34 12 CD AB 42 -> writes addr0=0x1234 and addr1=0xABCD, each one cycle after its second byte; load_done pulse; err_code=0.
- Range error: A5 3F 02 -> load_error after the COUNT byte, err_code=1, no write_en; busy falls. Repeat with COUNT=0 -> same result.
- Bad checksum: A5 00 01 FF 7F 00 -> addr0=0x7FFF written; load_error; err_code=2.
- Timeout: A5 05 01 11, then silence for TIMEOUT_CYCLES -> load_error, err_code=3, no write. A following valid frame then succeeds.
- Noise and back-to-back bytes: 00 55 A5 10 01 AA A5 (A5 as data) and checksum 10^01^AA^A5=0x1E, delivered on consecutive cycles -> addr0x10=0xA5AA (signed negative); load_done.
- Reset mid-frame: assert rst_n=0 after the first data byte -> all outputs 0 immediately, no write; the next full frame loads correctly.
